// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and forwarding control for a 5-stage MIPS pipeline.
// This block tracks the destination and result class of the instructions in E, M and W.
// From those entries it produces the E-stage and D-stage forward selects, the stall and
// flush controls, and a saturating count of stall cycles.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic             tuse_rs_D,
  input  logic             tuse_rt_D,
  input  logic [4:0]       dst_D,
  input  logic [1:0]       cls_D,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       ForwardAD,
  output logic [1:0]       ForwardBD,
  output logic             stall_D,
  output logic             flush_E,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] CLS_ALU  = 2'd1;
  localparam logic [1:0] CLS_LOAD = 2'd2;
  localparam logic [1:0] CLS_LINK = 2'd3;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_ALUM = 2'b01;
  localparam logic [1:0] FWD_RESW = 2'b10;
  localparam logic [1:0] FWD_PCM  = 2'b11;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] cls;
  } entry_t;

  localparam entry_t BUBBLE = '{rs: 5'd0, rt: 5'd0, dst: 5'd0, cls: 2'd0};

  entry_t e_q, m_q, w_q, e_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic stall_rs, stall_rt;

  // A source hits a stage only if that stage really writes a non-zero register.
  function automatic logic src_match(input logic [4:0] src, input entry_t ent);
    return (src == ent.dst) && (ent.dst != 5'd0) && (ent.cls != 2'd0);
  endfunction

  // E-stage select; a load sitting in M yields RF since the stall keeps that case unreachable.
  function automatic logic [1:0] fwd_e(input logic [4:0] src, input entry_t m, input entry_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src_match(src, m)) begin
      if (m.cls == CLS_ALU)       sel = FWD_ALUM;
      else if (m.cls == CLS_LINK) sel = FWD_PCM;
      else                        sel = FWD_RF;
    end else if (src_match(src, w)) begin
      sel = FWD_RESW;
    end
    return sel;
  endfunction

  // D-stage compare select; W needs no path because the register file writes through.
  function automatic logic [1:0] fwd_d(input logic [4:0] src, input entry_t m);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src_match(src, m)) begin
      if (m.cls == CLS_ALU)       sel = FWD_ALUM;
      else if (m.cls == CLS_LINK) sel = FWD_PCM;
    end
    return sel;
  endfunction

  // One source stalls when its value cannot be produced in time by any forward path.
  function automatic logic src_stall(input logic [4:0] src, input logic use_src,
                                     input logic tuse, input entry_t e, input entry_t m);
    logic hit_e, hit_m;
    hit_e = src_match(src, e) &&
            ((e.cls == CLS_LOAD) ||
             ((e.cls == CLS_ALU)  && !tuse) ||
             ((e.cls == CLS_LINK) && !tuse));
    hit_m = src_match(src, m) && (m.cls == CLS_LOAD) && !tuse;
    return use_src && (hit_e || hit_m);
  endfunction

  // Hazard detection, forward selects and next-state for the E entry and the counter.
  always_comb begin
    stall_rs      = src_stall(rs_D, use_rs_D, tuse_rs_D, e_q, m_q);
    stall_rt      = src_stall(rt_D, use_rt_D, tuse_rt_D, e_q, m_q);
    stall_D       = stall_rs | stall_rt;
    flush_E       = stall_D;
    ForwardAE     = fwd_e(e_q.rs, m_q, w_q);
    ForwardBE     = fwd_e(e_q.rt, m_q, w_q);
    ForwardAD     = fwd_d(rs_D, m_q);
    ForwardBD     = fwd_d(rt_D, m_q);
    e_d           = stall_D ? BUBBLE : '{rs: rs_D, rt: rt_D, dst: dst_D, cls: cls_D};
    stall_count_d = stall_count_q;
    if (stall_D && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Advance the tracking pipeline and the stall counter; reset takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q           <= BUBBLE;
      m_q           <= BUBBLE;
      w_q           <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      e_q           <= e_d;
      m_q           <= e_q;
      w_q           <= m_q;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer side of the E-stage forwarding interface for the 5-stage MIPS pipeline.
- Takes decoded hazard info for the instruction in D and tracks destination/result class for the instructions in E, M and W in a small internal pipeline.
- Drives ForwardAE/ForwardBE, which the E stage consumes; also drives D-stage branch-compare forward selects, stall_D (freezes PC and the IF/ID register) and flush_E (bubbles the ID/EX register).
- Keeps a saturating stall counter for performance debug.

Parameters:
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- rs_D  in  5  rs field of the instruction in D.
- rt_D  in  5  rt field of the instruction in D.
- use_rs_D  in  1  D instruction reads rs.
- use_rt_D  in  1  D instruction reads rt.
- tuse_rs_D  in  1  0 = rs needed in D (branch compare), 1 = needed in E.
- tuse_rt_D  in  1  same for rt.
- dst_D  in  5  register the D instruction writes; 0 = no write.
- cls_D  in  2  result class: 0 none, 1 ALU, 2 load, 3 link (jal/jalr, value PC+4).
- ForwardAE  out  2  E src A select: 00 RD1, 01 ALUOutM, 10 ResultW, 11 PC_M+4.
- ForwardBE  out  2  same encoding for E src B.
- ForwardAD  out  2  D rs compare select: 00 GRF, 01 ALUOutM, 11 PC_M+4.
- ForwardBD  out  2  same encoding for D rt.
- stall_D  out  1  hold PC and IF/ID.
- flush_E  out  1  load a bubble into ID/EX.
- stall_count  out  CNT_W  cycles with stall_D=1, saturating.

Behaviour:
- Tracking entries E, M and W, each {rs, rt, dst, cls}.
- Each clk:
  - W <= M; M <= E.
  - E <= {rs_D, rt_D, dst_D, cls_D} when stall_D=0.
  - E <= bubble (all fields 0) when stall_D=1.
- Reset: all entries become bubbles and stall_count=0. Outputs are combinational from the entries, so after reset: ForwardAE/BE/AD/BD=00, stall_D=0, flush_E=0.
- A source "matches" a stage when its field equals that stage's dst, dst!=0, and cls!=0. Register 0 never matches.
- Stall, rs (stall_rs); rt is symmetric with rt_D/tuse_rt_D/use_rt_D:
  - use_rs_D and E matches rs_D and any of:
    - E.cls=2;
    - E.cls=1 and tuse_rs_D=0;
    - E.cls=3 and tuse_rs_D=0.
  - Or use_rs_D and M matches rs_D, M.cls=2, tuse_rs_D=0.
- stall_D = stall_rs | stall_rt.
- flush_E = stall_D, asserted in the same cycle.
- ForwardAE, first match wins:
  1. M matches E.rs and M.cls=1 -> 01.
  2. M matches E.rs and M.cls=3 -> 11.
  3. W matches E.rs -> 10.
  4. Otherwise -> 00.
- ForwardBE: identical, using E.rt.
- M.cls=2 matching an E source cannot occur, because the stall prevents it. Benches must assert this never happens; the RTL outputs 00 in that case.
- ForwardAD, first match wins:
  1. M matches rs_D and M.cls=1 -> 01.
  2. M matches rs_D and M.cls=3 -> 11.
  3. Otherwise -> 00 (the GRF does W-to-D write-through).
- ForwardBD: same, using rt_D.
- Forward outputs are independent of stall_D. Consumers ignore D selects while stalled.
- stall_count increments on every clk with stall_D=1 and holds at all-ones. Synchronous reset overrides the increment.
- Reset asserted mid-stall: the next edge clears all entries and the counter, and stall_D drops in the same cycle reset deasserts.
- No latency beyond the entry pipeline: results are visible combinationally in the cycle the instruction occupies E or D.

Test Plan:
1. ALU chain, addu $3,$1,$2 then subu $4,$3,$5 (cls=1, dst=3; next rs=3, tuse=1) -> no stall. Cycle the subu is in E: ForwardAE=01. If a nop is inserted between them: ForwardAE=10.
2. Load-use, lw $8 (cls=2, dst=8) then addu rs=8 tuse=1 -> stall_D=flush_E=1 for exactly 1 cycle, then ForwardAE=10, stall_count=1.
3. Load-then-branch, lw $8 then beq rs=8 tuse=0 -> stall 2 cycles. After the stall, ForwardAD=00 (write-through); stall_count=2.
4. jal then jr $31 (cls=3, dst=31; tuse_rs=0) -> 1-cycle stall, then ForwardAD=11. jal then addu rs=31 in E -> ForwardAE=11.
5. Priority and $0:
   - M and W both write $6, E reads rs=6 -> ForwardAE=01.
   - dst=0 with cls=1 followed by a reader of $0 -> never stall, ForwardAE=00.
6. Reset during stall, and saturation:
   - Assert reset in the load-use stall cycle -> next cycle all outputs 0, stall_count=0.
   - With CNT_W=2, 5 stall cycles -> stall_count=3.
